// File: rtl/sd_crc_lanes.sv
// Multi-lane serial CRC engine (MSB-first, zero init) with unload and check sequencing.
// One CRC register per lane; a shared counter and FSM drive unload/check of CRC_W bits.
module sd_crc_lanes #(
  parameter int unsigned      CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = 16'h1021,
  parameter int unsigned      LANES = 4
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iclr,
  input  logic             ien,
  input  logic [LANES-1:0] idata,
  input  logic             iunload,
  input  logic             icheck,
  output logic [LANES-1:0] ocrc,
  output logic             ovalid,
  output logic             obusy,
  output logic             odone,
  output logic [LANES-1:0] oerr
);

  localparam int unsigned CntW = $clog2(CRC_W);

  typedef enum logic [1:0] {StIdle, StUnload, StCheck} state_e;

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q [LANES];
  logic [CRC_W-1:0] crc_d [LANES];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LANES-1:0] mis_q, mis_d;
  logic [LANES-1:0] err_q, err_d;
  logic             done_q, done_d;
  logic             last;

  assign last = (cnt_q == CntW'(CRC_W - 1));

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Accumulate first so a same-cycle start operates on the updated register.
        if (ien) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            crc_d[l] = {crc_q[l][CRC_W-2:0], 1'b0} ^
                       ((idata[l] ^ crc_q[l][CRC_W-1]) ? POLY : '0);
          end
        end
        if (iunload) begin
          state_d = StUnload;
          cnt_d   = '0;
          err_d   = '0;
          mis_d   = '0;
        end else if (icheck) begin
          state_d = StCheck;
          cnt_d   = '0;
          err_d   = '0;
          mis_d   = '0;
        end
      end
      StUnload: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          crc_d[l] = {crc_q[l][CRC_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      StCheck: begin
        if (ien) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            mis_d[l] = mis_q[l] | (idata[l] ^ crc_q[l][CRC_W-1]);
            crc_d[l] = {crc_q[l][CRC_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = mis_d;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst || iclr) begin
      state_q <= StIdle;
      for (int unsigned l = 0; l < LANES; l++) begin
        crc_q[l] <= '0;
      end
      cnt_q  <= '0;
      mis_q  <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ocrc = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ocrc[l] = crc_q[l][CRC_W-1];
    end
  end

  assign ovalid = (state_q == StUnload);
  assign obusy  = (state_q != StIdle);
  assign odone  = done_q;
  assign oerr   = err_q;

endmodule

// File: doc/sd_crc_lanes.md
# sd_crc_lanes

Parametrised multi-lane serial CRC engine for the SD host: one CRC register per lane, with a common polynomial and width. It covers both the command-line CRC7 (LANES=1, x^7+x^3+1) and the per-DAT-line CRC16 (LANES=4, x^16+x^12+x^5+1). It generates, shifts out and checks CRCs under a small state machine that reports completion and per-lane mismatch. It sits between the command/data drivers and the serialisers; CRC is computed MSB-first, with init value zero.

## Interface
Parameters:
- CRC_W, 16, CRC width in bits (>= 2).
- POLY, 16'h1021, generator polynomial without the x^CRC_W term (CRC7 uses 7'h09).
- LANES, 4, number of independent serial lanes.

Ports:
- iclk  in  1  clock; single clock domain.
- irst  in  1  reset, synchronous, active-high.
- iclr  in  1  clears all CRC registers, counter and oerr; aborts any operation.
- ien  in  1  bit strobe: idata is valid this cycle.
- idata  in  LANES  one serial data bit per lane.
- iunload  in  1  pulse: start shifting out CRC_W CRC bits.
- icheck  in  1  pulse: start comparing the next CRC_W received bits against the CRC.
- ocrc  out  LANES  MSB of each lane register (CRC bit stream during unload).
- ovalid  out  1  ocrc carries a CRC bit this cycle.
- obusy  out  1  engine is in UNLOAD or CHECK.
- odone  out  1  one-cycle pulse when an unload or check finishes.
- oerr  out  LANES  per-lane mismatch result of the last check; held until the next start, iclr or irst.

## Operation
- Per-lane update, lane l, when accumulating: fb = idata[l] ^ crc[l][CRC_W-1]; crc[l] <= {crc[l][CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0).
- Priority each cycle: irst > iclr > state actions. irst and iclr both give the state IDLE, all registers 0, counter 0, oerr 0, and no odone.
- IDLE:
  - ien=1 accumulates idata into every lane.
  - iunload=1 goes to UNLOAD; icheck=1 goes to CHECK. Both start the counter at 0 and clear oerr.
  - If iunload and icheck arrive together, iunload wins.
  - If ien and a start arrive in the same cycle, the ien bit is accumulated first. The start then takes effect on the updated register.
- UNLOAD (CRC_W cycles, ien ignored):
  - ovalid=1 and ocrc = current MSBs.
  - Each cycle the register shifts left with 0 in and the counter increments.
  - After count CRC_W-1 the state returns to IDLE with odone=1 for one cycle. Registers are then all 0, ready for the next block.
- CHECK (advances only on ien):
  - Each ien beat: mismatch[l] |= idata[l] ^ crc[l][CRC_W-1]; the register shifts left with 0 in; the counter increments.
  - After the CRC_W-th beat: state returns to IDLE, oerr <= mismatch, odone=1 for one cycle, registers are 0.
- iunload and icheck while obusy=1 are ignored.
- The counter is $clog2(CRC_W) bits wide and never wraps within an operation.

## Timing
- Reset values: ocrc=0, ovalid=0, obusy=0, odone=0, oerr=0.
- Accumulate latency: the register reflects a bit on the cycle after ien.
- Unload:
  - Pulse on edge N; edges N+1..N+CRC_W present CRC bits CRC_W-1..0 on ocrc with ovalid=1 and obusy=1.
  - odone=1 during the cycle after the last bit; ovalid=0 then.
  - Exactly CRC_W cycles with ovalid=1, no gaps.
- Check: odone is asserted the cycle after the edge sampling the CRC_W-th ien beat. oerr is valid in that same cycle and stays stable afterwards.
- A new start is accepted in the same cycle as odone (state is IDLE then).
- Back-to-back iunload pulses: the second is ignored unless obusy=0.
- iclr or irst mid-operation: ovalid, obusy and odone drop the next cycle, and no partial result is published.

## Test plan
- CRC7 (CRC_W=7, POLY=7'h09, LANES=1): shift 40 bits of 0x40_00_00_00_00, then iunload → 7 ovalid cycles giving 1001010 (0x4A), then odone, and the register reads 0.
- CRC16 (defaults): 4096 bits of 1 on all lanes, then iunload → each lane outputs 0x7FA1 MSB-first over 16 cycles; odone once.
- Check pass and fail:
  - Feed 0xFF×512 on all lanes, then icheck with lanes 0, 1 and 3 driving 0x7FA1 and lane 2 driving 0x7FA0 → oerr=4'b0100 with odone.
  - Insert ien gaps between check beats → same result; odone timing follows the 16th beat.
- Simultaneous events: iunload and icheck together → UNLOAD is taken. Pulsing icheck during UNLOAD is ignored → exactly 16 ovalid cycles and one odone.
- Abort: iclr at unload bit 5 → ovalid=0 and obusy=0 next cycle, no odone, register 0. A fresh 0xFF×512 run afterwards still yields 0x7FA1.
- Reset: assert irst mid-CHECK with oerr nonzero from a previous check → all outputs 0 the next cycle. Confirm irst is synchronous: no effect until a clock edge.
